// File: rtl/fir_pkg.sv
// Shared definitions for the FIR data RAM writer and the ring pointer.
package fir_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_WAIT_IN,
    ST_WRITE,
    ST_COMPUTE,
    ST_DONE
  } fir_state_e;

  localparam int unsigned TAPE_NUM_DEF = 11;
  localparam int unsigned ADDR_STRIDE  = 4;
  localparam logic [3:0]  WE_ALL       = 4'hF;
  localparam int unsigned PTR_W        = 4;

endpackage

// File: rtl/fir_ring_ptr.sv
// Modulo-Tape_Num slot counter: load presets to the last slot, inc advances with wrap.
module fir_ring_ptr
  import fir_pkg::*;
#(
  parameter int unsigned Tape_Num = TAPE_NUM_DEF,
  parameter int unsigned pWIDTH   = PTR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              inc,
  output logic [pWIDTH-1:0] ptr,
  output logic [pWIDTH-1:0] next_ptr
);

  localparam logic [pWIDTH-1:0] LAST = pWIDTH'(Tape_Num - 1);

  always_comb begin
    next_ptr = (ptr == LAST) ? '0 : ptr + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= LAST;
    end else if (load) begin
      ptr <= LAST;
    end else if (inc) begin
      ptr <= next_ptr;
    end
  end

endmodule

// File: rtl/fir_data_writer.sv
// Write side of the FIR data shift RAM: clears the tap RAM on start, then stores
// each stream sample into a circular buffer and hands the newest slot to compute.
module fir_data_writer
  import fir_pkg::*;
#(
  parameter int unsigned pADDR_WIDTH = 12,
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned Tape_Num    = TAPE_NUM_DEF
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   fir_start,
  input  logic [31:0]            data_len,
  input  logic                   ss_tvalid,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  input  logic                   ss_tlast,
  output logic                   ss_tready,
  output logic                   data_EN,
  output logic [3:0]             data_WE,
  output logic [pADDR_WIDTH-1:0] data_A,
  output logic [pDATA_WIDTH-1:0] data_Di,
  output logic                   sample_req,
  output logic [3:0]             head_ptr,
  input  logic                   compute_done,
  output logic                   busy,
  output logic                   writer_done,
  output logic                   last_err
);

  localparam logic [PTR_W-1:0] CLR_LAST = PTR_W'(Tape_Num - 1);

  fir_state_e state, state_nxt;

  logic [PTR_W-1:0]       clr_cnt;
  logic [31:0]            sample_cnt;
  logic [31:0]            len_q;
  logic [pADDR_WIDTH-1:0] addr_q;
  logic [pDATA_WIDTH-1:0] data_q;
  logic                   sample_req_q;
  logic                   last_err_q;
  logic [PTR_W-1:0]       slot_nxt;
  logic                   start_ok;
  logic                   clear_last;
  logic                   handshake;

  assign start_ok   = ((state == ST_IDLE) || (state == ST_DONE)) && fir_start;
  assign clear_last = (state == ST_CLEAR) && (clr_cnt == CLR_LAST);
  assign handshake  = (state == ST_WAIT_IN) && ss_tvalid;

  fir_ring_ptr #(
    .Tape_Num (Tape_Num),
    .pWIDTH   (PTR_W)
  ) u_head (
    .clk      (axis_clk),
    .rst_n    (axis_rst_n),
    .load     (clear_last),
    .inc      (handshake),
    .ptr      (head_ptr),
    .next_ptr (slot_nxt)
  );

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    ss_tready   = 1'b0;
    data_EN     = 1'b0;
    data_WE     = '0;
    data_A      = addr_q;
    data_Di     = data_q;
    busy        = 1'b1;
    writer_done = 1'b0;
    unique case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (fir_start) state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        data_EN = 1'b1;
        data_WE = WE_ALL;
        data_A  = pADDR_WIDTH'(clr_cnt) * pADDR_WIDTH'(ADDR_STRIDE);
        data_Di = '0;
        if (clear_last) state_nxt = (len_q == 32'd0) ? ST_DONE : ST_WAIT_IN;
      end
      ST_WAIT_IN: begin
        ss_tready = 1'b1;
        if (ss_tvalid) state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        data_EN   = 1'b1;
        data_WE   = WE_ALL;
        state_nxt = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        if (compute_done) state_nxt = (sample_cnt == len_q) ? ST_DONE : ST_WAIT_IN;
      end
      ST_DONE: begin
        busy        = 1'b0;
        writer_done = 1'b1;
        if (fir_start) state_nxt = ST_CLEAR;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      clr_cnt      <= '0;
      sample_cnt   <= '0;
      len_q        <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      sample_req_q <= 1'b0;
      last_err_q   <= 1'b0;
    end else begin
      // Registered so the pulse covers only the first COMPUTE cycle.
      sample_req_q <= (state == ST_WRITE);
      if (start_ok) begin
        len_q      <= data_len;
        sample_cnt <= '0;
        last_err_q <= 1'b0;
        clr_cnt    <= '0;
      end
      if ((state == ST_CLEAR) && !clear_last) begin
        clr_cnt <= clr_cnt + 1'b1;
      end
      if (handshake) begin
        data_q     <= ss_tdata;
        addr_q     <= pADDR_WIDTH'(slot_nxt) * pADDR_WIDTH'(ADDR_STRIDE);
        sample_cnt <= sample_cnt + 32'd1;
        if (ss_tlast != ((sample_cnt + 32'd1) == len_q)) last_err_q <= 1'b1;
      end
    end
  end

  assign sample_req = sample_req_q;
  assign last_err   = last_err_q;

endmodule

// File: tb/tb_fir_data_writer.sv
// Directed + randomized bench for fir_data_writer against a circular-buffer model.
module tb_fir_data_writer;
  import fir_pkg::*;

  localparam int unsigned TN = 11;

  logic        axis_clk = 1'b0;
  logic        axis_rst_n;
  logic        fir_start;
  logic [31:0] data_len;
  logic        ss_tvalid;
  logic [31:0] ss_tdata;
  logic        ss_tlast;
  logic        ss_tready;
  logic        data_EN;
  logic [3:0]  data_WE;
  logic [11:0] data_A;
  logic [31:0] data_Di;
  logic        sample_req;
  logic [3:0]  head_ptr;
  logic        compute_done;
  logic        busy;
  logic        writer_done;
  logic        last_err;

  fir_data_writer #(
    .pADDR_WIDTH (12),
    .pDATA_WIDTH (32),
    .Tape_Num    (TN)
  ) dut (
    .axis_clk     (axis_clk),
    .axis_rst_n   (axis_rst_n),
    .fir_start    (fir_start),
    .data_len     (data_len),
    .ss_tvalid    (ss_tvalid),
    .ss_tdata     (ss_tdata),
    .ss_tlast     (ss_tlast),
    .ss_tready    (ss_tready),
    .data_EN      (data_EN),
    .data_WE      (data_WE),
    .data_A       (data_A),
    .data_Di      (data_Di),
    .sample_req   (sample_req),
    .head_ptr     (head_ptr),
    .compute_done (compute_done),
    .busy         (busy),
    .writer_done  (writer_done),
    .last_err     (last_err)
  );

  always #5 axis_clk = ~axis_clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;
  int unsigned bad_we   = 0;
  int unsigned cdelay   = 2;

  logic [11:0] wr_a_q[$];
  logic [31:0] wr_d_q[$];
  logic [3:0]  head_q[$];
  int unsigned hs_q[$];
  logic [31:0] exp_d[$];

  // Observation only: log every BRAM write, sample_req slot and handshake cycle.
  always @(posedge axis_clk) begin
    cyc++;
    if (axis_rst_n) begin
      if (data_EN && data_WE !== 4'hF) bad_we++;
      if (!data_EN && data_WE !== 4'h0) bad_we++;
      if (data_EN && data_WE != 4'h0) begin
        wr_a_q.push_back(data_A);
        wr_d_q.push_back(data_Di);
      end
      if (sample_req) head_q.push_back(head_ptr);
      if (ss_tvalid && ss_tready) hs_q.push_back(cyc);
    end
  end

  // Compute engine stand-in: answers each sample_req after cdelay cycles.
  initial begin
    compute_done = 1'b0;
    forever begin
      @(posedge axis_clk); #1;
      compute_done = 1'b0;
      if (sample_req && axis_rst_n) begin
        if (cdelay > 0) begin
          repeat (cdelay) @(posedge axis_clk);
          #1;
        end
        compute_done = 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_run(input logic [31:0] len);
    wr_a_q.delete();
    wr_d_q.delete();
    head_q.delete();
    hs_q.delete();
    exp_d.delete();
    fir_start = 1'b1;
    data_len  = len;
    @(posedge axis_clk); #1;
    fir_start = 1'b0;
  endtask

  // mode 0: random data, 1: i+1, 2: i. tlast_at<0 places tlast on the final sample.
  task automatic send_stream(input int unsigned len, input int tlast_at,
                             input bit gaps, input int mode);
    for (int unsigned i = 0; i < len; i++) begin
      logic [31:0] v;
      int unsigned b;
      case (mode)
        1:       v = i + 1;
        2:       v = i;
        default: v = $urandom;
      endcase
      exp_d.push_back(v);
      ss_tdata  = v;
      ss_tvalid = 1'b1;
      ss_tlast  = (tlast_at < 0) ? (i == len - 1) : (int'(i) == tlast_at);
      b = 0;
      while (!ss_tready && b < 300) begin
        @(posedge axis_clk); #1;
        b++;
      end
      if (b >= 300) begin
        check("handshake_timeout", 64'(ss_tready), 64'd1);
        ss_tvalid = 1'b0;
        ss_tlast  = 1'b0;
        return;
      end
      @(posedge axis_clk); #1;
      if (gaps) begin
        ss_tvalid = 1'b0;
        ss_tlast  = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge axis_clk);
        #0;
      end
    end
    ss_tvalid = 1'b0;
    ss_tlast  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int unsigned b = 0;
    while (!writer_done && b < 600) begin
      @(posedge axis_clk); #1;
      b++;
    end
    check({tag, "_writer_done"}, 64'(writer_done), 64'd1);
  endtask

  task automatic verify_run(input string tag, input int unsigned len, input logic exp_err);
    check({tag, "_n_writes"}, 64'(wr_a_q.size()), 64'(TN + len));
    check({tag, "_n_sample_req"}, 64'(head_q.size()), 64'(len));
    for (int unsigned k = 0; k < wr_a_q.size() && k < TN + len; k++) begin
      logic [11:0] ea;
      logic [31:0] ed;
      if (k < TN) begin
        ea = 12'(k * 4);
        ed = '0;
      end else begin
        ea = 12'(((k - TN) % TN) * 4);
        ed = exp_d[k - TN];
      end
      check($sformatf("%s_addr%0d", tag, k), 64'(wr_a_q[k]), 64'(ea));
      check($sformatf("%s_data%0d", tag, k), 64'(wr_d_q[k]), 64'(ed));
    end
    for (int unsigned i = 0; i < head_q.size() && i < len; i++) begin
      check($sformatf("%s_head%0d", tag, i), 64'(head_q[i]), 64'(i % TN));
    end
    check({tag, "_last_err"}, 64'(last_err), 64'(exp_err));
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_bad_we"}, 64'(bad_we), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_EN"}, 64'(data_EN), 64'd0);
    check({tag, "_WE"}, 64'(data_WE), 64'd0);
    check({tag, "_A"}, 64'(data_A), 64'd0);
    check({tag, "_Di"}, 64'(data_Di), 64'd0);
    check({tag, "_tready"}, 64'(ss_tready), 64'd0);
    check({tag, "_sample_req"}, 64'(sample_req), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_writer_done"}, 64'(writer_done), 64'd0);
    check({tag, "_last_err"}, 64'(last_err), 64'd0);
    check({tag, "_head_ptr"}, 64'(head_ptr), 64'(TN - 1));
  endtask

  initial begin
    int unsigned b;
    axis_rst_n = 1'b0;
    fir_start  = 1'b0;
    data_len   = '0;
    ss_tvalid  = 1'b0;
    ss_tdata   = '0;
    ss_tlast   = 1'b0;

    #12;
    check_reset_outputs("por");
    @(posedge axis_clk); #1;
    axis_rst_n = 1'b1;
    @(posedge axis_clk); #1;

    // Reset while in COMPUTE with a slow compute engine.
    cdelay = 50;
    start_run(32'd3);
    send_stream(1, -1, 1'b1, 0);
    b = 0;
    while (!sample_req && b < 50) begin
      @(posedge axis_clk); #1;
      b++;
    end
    check("midrst_reached_compute", 64'(sample_req), 64'd1);
    axis_rst_n = 1'b0;
    #2;
    check_reset_outputs("midrst");
    @(posedge axis_clk); #1;
    axis_rst_n = 1'b1;
    repeat (60) @(posedge axis_clk);
    #1;
    check("midrst_idle_after_stray_done", 64'(busy), 64'd0);

    // data_len=0: clear only; a second start during CLEAR must be ignored.
    start_run(32'd0);
    repeat (4) @(posedge axis_clk);
    #1;
    fir_start = 1'b1;
    data_len  = 32'd5;
    @(posedge axis_clk); #1;
    fir_start = 1'b0;
    data_len  = 32'd0;
    wait_done("len0");
    verify_run("len0", 0, 1'b0);
    repeat (3) @(posedge axis_clk);
    #1;
    check("len0_done_held", 64'(writer_done), 64'd1);
    check("len0_no_late_sample_req", 64'(head_q.size()), 64'd0);

    cdelay = 2;
    start_run(32'd3);
    check("len3_last_err_cleared", 64'(last_err), 64'd0);
    check("len3_done_cleared", 64'(writer_done), 64'd0);
    send_stream(3, -1, 1'b1, 1);
    wait_done("len3");
    verify_run("len3", 3, 1'b0);

    start_run(32'd13);
    send_stream(13, -1, 1'b1, 2);
    wait_done("len13");
    verify_run("len13", 13, 1'b0);

    // Back-to-back: tvalid held high, compute answers in the first COMPUTE cycle.
    cdelay = 0;
    start_run(32'd8);
    send_stream(8, -1, 1'b0, 0);
    wait_done("cont");
    verify_run("cont", 8, 1'b0);
    for (int unsigned i = 1; i < hs_q.size(); i++) begin
      check($sformatf("cont_hs_spacing%0d", i), 64'(hs_q[i] - hs_q[i-1]), 64'd3);
    end

    cdelay = 1;
    start_run(32'd4);
    send_stream(4, 1, 1'b1, 0);
    wait_done("tlast_err");
    verify_run("tlast_err", 4, 1'b1);

    for (int r = 0; r < 3; r++) begin
      int unsigned len;
      len    = $urandom_range(1, 15);
      cdelay = $urandom_range(0, 4);
      start_run(len);
      check($sformatf("rand%0d_last_err_cleared", r), 64'(last_err), 64'd0);
      send_stream(len, -1, 1'($urandom_range(0, 1)), 0);
      wait_done($sformatf("rand%0d", r));
      verify_run($sformatf("rand%0d", r), len, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
